// File: rtl/pour_scheduler.sv
// pour_scheduler: runs red, yellow, blue dispense channels one at a time
// (lower, hold, raise) for one colour recipe, with safe abort.
// Ports: clk, rst (sync, active-high); req_valid/req_color/req_ready
// request handshake; abort level input; motor_en[2:0] one-hot channel
// enable, motor_dir (1 = raise), active_ch (3 = none); done/aborted
// recipe-end pulse; err pulse on an invalid colour.
module pour_scheduler #(
    parameter int TICK_DIV    = 4194304,
    parameter int DEPTH_STEPS = 5,
    parameter int HOLD_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_color,
    output logic       req_ready,
    input  logic       abort,
    output logic [2:0] motor_en,
    output logic       motor_dir,
    output logic [1:0] active_ch,
    output logic       done,
    output logic       aborted,
    output logic       err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH_STEPS);
    localparam logic [15:0] HOLD16  = 16'(HOLD_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        LOWER,
        HOLD,
        RAISE,
        DONE,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [1:0]    ch, ch_n;
    logic [3:0]    color, color_n;
    logic [PW-1:0] pres, pres_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   lowered, lowered_n;
    logic [15:0]   lowered_inc;
    logic          flag, flag_n;
    logic          tick;

    // Units per channel {b, y, r}; depth and hold share the unit count.
    function automatic logic [1:0] unit_of(
        input logic [3:0] col,
        input logic [1:0] c
    );
        logic [5:0] row;
        case (col)
            4'd0:    row = {2'd1, 2'd1, 2'd1};
            4'd1:    row = {2'd1, 2'd1, 2'd2};
            4'd2:    row = {2'd1, 2'd2, 2'd1};
            4'd3:    row = {2'd2, 2'd1, 2'd1};
            4'd4:    row = {2'd1, 2'd2, 2'd2};
            4'd5:    row = {2'd2, 2'd2, 2'd1};
            4'd6:    row = {2'd2, 2'd1, 2'd2};
            4'd7:    row = {2'd1, 2'd2, 2'd3};
            4'd8:    row = {2'd2, 2'd1, 2'd3};
            4'd9:    row = {2'd1, 2'd3, 2'd2};
            4'd10:   row = {2'd2, 2'd3, 2'd1};
            4'd11:   row = {2'd3, 2'd1, 2'd2};
            default: row = 6'd0;
        endcase
        case (c)
            2'd0:    return row[1:0];
            2'd1:    return row[3:2];
            2'd2:    return row[5:4];
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [15:0] dur(
        input logic [15:0] per,
        input logic [1:0]  u
    );
        return per * {14'd0, u};
    endfunction

    assign tick        = (pres == PRE_MAX);
    assign lowered_inc = lowered + {15'd0, tick};

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        color_n   = color;
        cnt_n     = cnt;
        lowered_n = lowered;
        flag_n    = flag;
        pres_n    = tick ? '0 : pres + 1'b1;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    color_n = req_color;
                    pres_n  = '0;
                    flag_n  = 1'b0;
                    if (req_color < 4'd12) begin
                        state_n   = LOWER;
                        ch_n      = 2'd0;
                        lowered_n = '0;
                        cnt_n     = dur(DEPTH16,
                                        unit_of(req_color, 2'd0));
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            LOWER: begin
                lowered_n = lowered_inc;
                if (tick)
                    cnt_n = cnt - 16'd1;
                if (abort) begin
                    // Retract exactly what went down, tick included.
                    flag_n = 1'b1;
                    if (lowered_inc == 16'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RAISE;
                        cnt_n   = lowered_inc;
                    end
                end else if (tick && cnt == 16'd1) begin
                    state_n = HOLD;
                    cnt_n   = dur(HOLD16, unit_of(color, ch));
                end
            end
            HOLD: begin
                if (tick)
                    cnt_n = cnt - 16'd1;
                if (abort)
                    flag_n = 1'b1;
                if (abort || (tick && cnt == 16'd1)) begin
                    state_n = RAISE;
                    cnt_n   = lowered;
                end
            end
            RAISE: begin
                if (abort)
                    flag_n = 1'b1;
                if (tick)
                    cnt_n = cnt - 16'd1;
                if (tick && cnt == 16'd1) begin
                    if (flag_n || ch == 2'd2) begin
                        state_n = DONE;
                    end else begin
                        state_n   = LOWER;
                        ch_n      = ch + 2'd1;
                        lowered_n = '0;
                        cnt_n     = dur(DEPTH16,
                                        unit_of(color, ch + 2'd1));
                    end
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line
    // up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= 2'd0;
            color     <= 4'd0;
            pres      <= '0;
            cnt       <= '0;
            lowered   <= '0;
            flag      <= 1'b0;
            req_ready <= 1'b1;
            motor_en  <= 3'b000;
            motor_dir <= 1'b0;
            active_ch <= 2'd3;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ch        <= ch_n;
            color     <= color_n;
            pres      <= pres_n;
            cnt       <= cnt_n;
            lowered   <= lowered_n;
            flag      <= flag_n;
            req_ready <= (state_n == IDLE);
            motor_en  <= (state_n == LOWER || state_n == RAISE)
                         ? (3'b001 << ch_n) : 3'b000;
            motor_dir <= (state_n == RAISE);
            active_ch <= (state_n == LOWER || state_n == HOLD ||
                          state_n == RAISE) ? ch_n : 2'd3;
            done      <= (state_n == DONE);
            aborted   <= (state_n == DONE) && flag_n;
            err       <= (state_n == ERR);
        end
    end

endmodule

// File: tb/tb_pour_scheduler.sv
// tb_pour_scheduler: directed checks of pour_scheduler with
// TICK_DIV=4, DEPTH_STEPS=2, HOLD_TICKS=3.
module tb_pour_scheduler;

    localparam int TD = 4;
    localparam int DS = 2;
    localparam int HT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_color = 4'd0;
    logic       req_ready;
    logic       abort = 1'b0;
    logic [2:0] motor_en;
    logic       motor_dir;
    logic [1:0] active_ch;
    logic       done;
    logic       aborted;
    logic       err;

    int checks = 0;
    int errors = 0;

    // {en, dir, act, done, aborted, err, ready}
    logic [9:0] obs;
    assign obs = {motor_en, motor_dir, active_ch,
                  done, aborted, err, req_ready};

    localparam logic [9:0] IDLE_V = {3'b000, 1'b0, 2'd3, 4'b0001};

    pour_scheduler #(
        .TICK_DIV(TD),
        .DEPTH_STEPS(DS),
        .HOLD_TICKS(HT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_color(req_color),
        .req_ready(req_ready),
        .abort(abort),
        .motor_en(motor_en),
        .motor_dir(motor_dir),
        .active_ch(active_ch),
        .done(done),
        .aborted(aborted),
        .err(err)
    );

    always #5 clk = ~clk;

    // Expected outputs in cycle c of an unaborted recipe.
    function automatic logic [9:0] exp_full(
        input int r, input int y, input int b, input int c
    );
        int u[3];
        int t;
        int lo;
        int ho;
        u[0] = r;
        u[1] = y;
        u[2] = b;
        t = c - 1;
        for (int k = 0; k < 3; k++) begin
            lo = u[k] * DS * TD;
            ho = u[k] * HT * TD;
            if (t < lo)
                return {3'(1 << k), 1'b0, 2'(k), 4'b0000};
            t -= lo;
            if (t < ho)
                return {3'b000, 1'b0, 2'(k), 4'b0000};
            t -= ho;
            if (t < lo)
                return {3'(1 << k), 1'b1, 2'(k), 4'b0000};
            t -= lo;
        end
        if (t == 0)
            return {3'b000, 1'b0, 2'd3, 4'b1000};
        return IDLE_V;
    endfunction

    // Expected outputs for a red-only run cut short by abort.
    function automatic logic [9:0] exp_abort(
        input int c, input int le, input int he,
        input int re, input int dc
    );
        if (c <= le)
            return {3'b001, 1'b0, 2'd0, 4'b0000};
        if (c <= he)
            return {3'b000, 1'b0, 2'd0, 4'b0000};
        if (c <= re)
            return {3'b001, 1'b1, 2'd0, 4'b0000};
        if (c == dc)
            return {3'b000, 1'b0, 2'd3, 4'b1100};
        return IDLE_V;
    endfunction

    task automatic accept(input logic [3:0] col);
        @(negedge clk);
        req_valid = 1'b1;
        req_color = col;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b expected 1",
                     req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset_hold got %b expected %b",
                     obs, IDLE_V);
        end
        rst = 1'b0;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL idle_abort got %b expected %b",
                     obs, IDLE_V);
        end
    endtask

    task automatic run_trace(
        input string name, input logic [3:0] col,
        input int r, input int y, input int b, input int last
    );
        logic [9:0] e;
        accept(col);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            e = exp_full(r, y, b, c);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d got %b expected %b",
                         name, c, obs, e);
            end
            checks++;
            if ($countones(motor_en) > 1) begin
                errors++;
                $display("FAIL %s_onehot cycle %0d got %b expected <=1",
                         name, c, motor_en);
            end
        end
    endtask

    task automatic test_colour0();
        run_trace("colour0", 4'd0, 1, 1, 1, 87);
    endtask

    task automatic test_colour7();
        run_trace("colour7", 4'd7, 3, 2, 1, 171);
    endtask

    task automatic test_invalid();
        logic [9:0] e;
        accept(4'd13);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e = (c == 1) ? {3'b000, 1'b0, 2'd3, 4'b0010} : IDLE_V;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL invalid cycle %0d got %b expected %b",
                         c, obs, e);
            end
        end
    endtask

    task automatic run_abort(
        input string name, input logic [3:0] col, input int k,
        input int le, input int he, input int re, input int dc
    );
        logic [9:0] e;
        accept(col);
        for (int c = 1; c <= dc + 2; c++) begin
            @(negedge clk);
            e = exp_abort(c, le, he, re, dc);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d got %b expected %b",
                         name, c, obs, e);
            end
            abort = (c == k);
        end
        abort = 1'b0;
    endtask

    task automatic test_abort();
        run_abort("abort_lower", 4'd3, 5, 5, 5, 8, 9);
        run_abort("abort_on_tick", 4'd0, 4, 4, 4, 8, 9);
        run_abort("abort_no_tick", 4'd0, 2, 2, 2, 2, 3);
        run_abort("abort_hold", 4'd0, 10, 8, 10, 16, 17);
        run_abort("abort_raise", 4'd0, 22, 8, 20, 28, 29);
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        @(negedge clk);
        req_valid = 1'b1;
        req_color = 4'd1;
        @(posedge clk);
        for (int c = 1; c <= 114; c++) begin
            @(negedge clk);
            e = exp_full(2, 1, 1, c);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b_first cycle %0d got %b expected %b",
                         c, obs, e);
            end
        end
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            e = exp_full(2, 1, 1, c);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b_second cycle %0d got %b expected %b",
                         c, obs, e);
            end
        end
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL mid_reset got %b expected %b",
                     obs, IDLE_V);
        end
        @(negedge clk);
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL post_reset got %b expected %b",
                     obs, IDLE_V);
        end
    endtask

    initial begin
        test_reset();
        test_colour0();
        test_colour7();
        test_invalid();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
